// File: rtl/qea_run_sequencer.sv
// Run sequencer for the QEA core: loads gate context, seeds the state RAM, starts the core and
// streams the result rows out. Define QEA_SEQ_CYCLE_COUNT_EN to add the o_exec_cycles counter.
module qea_run_sequencer #(
   parameter int PE_NUM_WIDTH            = 2,
   parameter int PE_NUM                  = 4,
   parameter int MAX_QBIT_WIDTH          = 6,
   parameter int STATE_DATA_WIDTH        = 64,
   parameter int STATE_ADDR_WIDTH        = 16,
   parameter int GATE_CONTEXT_DATA_WIDTH = 64,
   parameter int GATE_CONTEXT_ADDR_WIDTH = 16
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic                                 i_cmd_valid,
   output logic                                 o_cmd_ready,
   input  logic [MAX_QBIT_WIDTH-1:0]            i_cmd_qbit_num,
   input  logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   i_cmd_ins_num,
   input  logic                                 i_abort,
   input  logic                                 i_ctx_valid,
   output logic                                 o_ctx_ready,
   input  logic [GATE_CONTEXT_DATA_WIDTH-1:0]   i_ctx_data,
   output logic                                 o_rd_valid,
   input  logic                                 i_rd_ready,
   output logic [PE_NUM*STATE_DATA_WIDTH-1:0]   o_rd_data,
   output logic                                 o_rd_last,
   output logic                                 o_err,
   output logic                                 o_busy,
   output logic                                 o_qea_start,
   output logic [MAX_QBIT_WIDTH-1:0]            o_qea_qbit_num,
   output logic                                 o_qea_ctx_en,
   output logic                                 o_qea_ctx_wea,
   output logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   o_qea_ctx_addr,
   output logic [GATE_CONTEXT_DATA_WIDTH-1:0]   o_qea_ctx_data,
   output logic                                 o_qea_state_ena,
   output logic                                 o_qea_state_wea,
   output logic [STATE_ADDR_WIDTH-1:0]          o_qea_state_addra,
   output logic [PE_NUM*STATE_DATA_WIDTH-1:0]   o_qea_state_dina,
   input  logic                                 i_qea_complete,
`ifdef QEA_SEQ_CYCLE_COUNT_EN
   output logic [31:0]                          o_exec_cycles,
`endif
   input  logic [PE_NUM*STATE_DATA_WIDTH-1:0]   i_qea_state_dout
);

   localparam int ROW_W = PE_NUM * STATE_DATA_WIDTH;
   // Q2.30 real part of 1.0 in the upper half, imaginary part zero
   localparam logic [STATE_DATA_WIDTH-1:0] AMP_ONE = {2'b01, {(STATE_DATA_WIDTH-2){1'b0}}};
   localparam logic [ROW_W-1:0] INIT_ROW0 =
      {AMP_ONE, {((PE_NUM-1)*STATE_DATA_WIDTH){1'b0}}};

   typedef enum logic [2:0] {
      StIdle, StLoadCtx, StInitState, StStart, StRun, StReadAddr, StReadWait, StReadHold
   } state_e;

   state_e                              state_q;
   logic [GATE_CONTEXT_ADDR_WIDTH-1:0]  ins_q;
   logic [GATE_CONTEXT_ADDR_WIDTH-1:0]  ctx_idx_q;
   logic [STATE_ADDR_WIDTH-1:0]         rows_last_q;
   logic [STATE_ADDR_WIDTH-1:0]         row_q;

   logic                                cmd_fire;
   logic                                qbit_ok;
   logic [MAX_QBIT_WIDTH-1:0]           shamt;
   logic [STATE_ADDR_WIDTH:0]           rows_full;
   logic [STATE_ADDR_WIDTH-1:0]         cmd_rows_last;
   logic                                ctx_last;
   logic                                row_last;

   always_comb begin
      cmd_fire      = (state_q == StIdle) && i_cmd_valid && o_cmd_ready;
      qbit_ok       = (int'(i_cmd_qbit_num) > PE_NUM_WIDTH) &&
                      (int'(i_cmd_qbit_num) <= STATE_ADDR_WIDTH + PE_NUM_WIDTH);
      shamt         = i_cmd_qbit_num - MAX_QBIT_WIDTH'(PE_NUM_WIDTH);
      // One extra bit so a full 2^STATE_ADDR_WIDTH row count wraps to an all-ones last index
      rows_full     = (STATE_ADDR_WIDTH+1)'(1) << shamt;
      cmd_rows_last = rows_full[STATE_ADDR_WIDTH-1:0] - STATE_ADDR_WIDTH'(1);
      ctx_last      = (ctx_idx_q == ins_q - GATE_CONTEXT_ADDR_WIDTH'(1));
      row_last      = (row_q == rows_last_q);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q           <= StIdle;
         ins_q             <= '0;
         ctx_idx_q         <= '0;
         rows_last_q       <= '0;
         row_q             <= '0;
         o_cmd_ready       <= 1'b0;
         o_ctx_ready       <= 1'b0;
         o_rd_valid        <= 1'b0;
         o_rd_data         <= '0;
         o_rd_last         <= 1'b0;
         o_err             <= 1'b0;
         o_busy            <= 1'b0;
         o_qea_start       <= 1'b0;
         o_qea_qbit_num    <= '0;
         o_qea_ctx_en      <= 1'b0;
         o_qea_ctx_wea     <= 1'b0;
         o_qea_ctx_addr    <= '0;
         o_qea_ctx_data    <= '0;
         o_qea_state_ena   <= 1'b0;
         o_qea_state_wea   <= 1'b0;
         o_qea_state_addra <= '0;
         o_qea_state_dina  <= '0;
      end else begin
         o_err           <= 1'b0;
         o_qea_start     <= 1'b0;
         o_qea_ctx_en    <= 1'b0;
         o_qea_ctx_wea   <= 1'b0;
         o_qea_state_ena <= 1'b0;
         o_qea_state_wea <= 1'b0;
         if (state_q != StIdle && i_abort) begin
            state_q     <= StIdle;
            o_cmd_ready <= 1'b1;
            o_busy      <= 1'b0;
            o_ctx_ready <= 1'b0;
            o_rd_valid  <= 1'b0;
            o_rd_last   <= 1'b0;
         end else begin
            case (state_q)
               StIdle: begin
                  o_cmd_ready <= 1'b1;
                  if (cmd_fire) begin
                     if (!qbit_ok) begin
                        o_err <= 1'b1;
                     end else begin
                        o_cmd_ready    <= 1'b0;
                        o_busy         <= 1'b1;
                        o_qea_qbit_num <= i_cmd_qbit_num;
                        ins_q          <= i_cmd_ins_num;
                        rows_last_q    <= cmd_rows_last;
                        ctx_idx_q      <= '0;
                        row_q          <= '0;
                        if (i_cmd_ins_num == '0) begin
                           state_q           <= StInitState;
                           o_qea_state_ena   <= 1'b1;
                           o_qea_state_wea   <= 1'b1;
                           o_qea_state_addra <= '0;
                           o_qea_state_dina  <= INIT_ROW0;
                        end else begin
                           state_q     <= StLoadCtx;
                           o_ctx_ready <= 1'b1;
                        end
                     end
                  end
               end
               StLoadCtx: begin
                  if (i_ctx_valid && o_ctx_ready) begin
                     o_qea_ctx_en   <= 1'b1;
                     o_qea_ctx_wea  <= 1'b1;
                     o_qea_ctx_addr <= ctx_idx_q;
                     o_qea_ctx_data <= i_ctx_data;
                     ctx_idx_q      <= ctx_idx_q + GATE_CONTEXT_ADDR_WIDTH'(1);
                     if (ctx_last) begin
                        state_q           <= StInitState;
                        o_ctx_ready       <= 1'b0;
                        o_qea_state_ena   <= 1'b1;
                        o_qea_state_wea   <= 1'b1;
                        o_qea_state_addra <= '0;
                        o_qea_state_dina  <= INIT_ROW0;
                     end
                  end
               end
               // row_q tracks the row currently presented on the state RAM port
               StInitState: begin
                  if (row_last) begin
                     state_q     <= StStart;
                     o_qea_start <= 1'b1;
                  end else begin
                     row_q             <= row_q + STATE_ADDR_WIDTH'(1);
                     o_qea_state_ena   <= 1'b1;
                     o_qea_state_wea   <= 1'b1;
                     o_qea_state_addra <= row_q + STATE_ADDR_WIDTH'(1);
                     o_qea_state_dina  <= '0;
                  end
               end
               StStart: begin
                  state_q <= StRun;
               end
               StRun: begin
                  if (i_qea_complete) begin
                     state_q           <= StReadAddr;
                     row_q             <= '0;
                     o_qea_state_ena   <= 1'b1;
                     o_qea_state_addra <= '0;
                  end
               end
               StReadAddr: begin
                  state_q <= StReadWait;
               end
               StReadWait: begin
                  state_q    <= StReadHold;
                  o_rd_data  <= i_qea_state_dout;
                  o_rd_valid <= 1'b1;
                  o_rd_last  <= row_last;
               end
               StReadHold: begin
                  if (i_rd_ready) begin
                     o_rd_valid <= 1'b0;
                     o_rd_last  <= 1'b0;
                     if (row_last) begin
                        state_q     <= StIdle;
                        o_cmd_ready <= 1'b1;
                        o_busy      <= 1'b0;
                     end else begin
                        state_q           <= StReadAddr;
                        row_q             <= row_q + STATE_ADDR_WIDTH'(1);
                        o_qea_state_ena   <= 1'b1;
                        o_qea_state_addra <= row_q + STATE_ADDR_WIDTH'(1);
                     end
                  end
               end
               default: begin
                  state_q <= StIdle;
               end
            endcase
         end
      end
   end

`ifdef QEA_SEQ_CYCLE_COUNT_EN
   // Counts the START cycle plus every RUN cycle before complete is first seen
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         o_exec_cycles <= '0;
      end else if (cmd_fire && qbit_ok) begin
         o_exec_cycles <= '0;
      end else if ((state_q == StStart || (state_q == StRun && !i_qea_complete)) &&
                   o_exec_cycles != 32'hFFFF_FFFF) begin
         o_exec_cycles <= o_exec_cycles + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_qea_run_sequencer.sv
// Directed bench for qea_run_sequencer with a behavioural state RAM and QEA core.
// Build with QEA_SEQ_CYCLE_COUNT_EN defined to also check o_exec_cycles.
module tb_qea_run_sequencer;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          i_cmd_valid = 1'b0;
   logic          o_cmd_ready;
   logic [5:0]    i_cmd_qbit_num = '0;
   logic [15:0]   i_cmd_ins_num = '0;
   logic          i_abort = 1'b0;
   logic          i_ctx_valid = 1'b0;
   logic          o_ctx_ready;
   logic [63:0]   i_ctx_data = '0;
   logic          o_rd_valid;
   logic          i_rd_ready = 1'b0;
   logic [255:0]  o_rd_data;
   logic          o_rd_last;
   logic          o_err;
   logic          o_busy;
   logic          o_qea_start;
   logic [5:0]    o_qea_qbit_num;
   logic          o_qea_ctx_en;
   logic          o_qea_ctx_wea;
   logic [15:0]   o_qea_ctx_addr;
   logic [63:0]   o_qea_ctx_data;
   logic          o_qea_state_ena;
   logic          o_qea_state_wea;
   logic [15:0]   o_qea_state_addra;
   logic [255:0]  o_qea_state_dina;
   logic          i_qea_complete = 1'b0;
   logic [255:0]  i_qea_state_dout = '0;
`ifdef QEA_SEQ_CYCLE_COUNT_EN
   logic [31:0]   o_exec_cycles;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   qea_run_sequencer dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .i_cmd_valid       (i_cmd_valid),
      .o_cmd_ready       (o_cmd_ready),
      .i_cmd_qbit_num    (i_cmd_qbit_num),
      .i_cmd_ins_num     (i_cmd_ins_num),
      .i_abort           (i_abort),
      .i_ctx_valid       (i_ctx_valid),
      .o_ctx_ready       (o_ctx_ready),
      .i_ctx_data        (i_ctx_data),
      .o_rd_valid        (o_rd_valid),
      .i_rd_ready        (i_rd_ready),
      .o_rd_data         (o_rd_data),
      .o_rd_last         (o_rd_last),
      .o_err             (o_err),
      .o_busy            (o_busy),
      .o_qea_start       (o_qea_start),
      .o_qea_qbit_num    (o_qea_qbit_num),
      .o_qea_ctx_en      (o_qea_ctx_en),
      .o_qea_ctx_wea     (o_qea_ctx_wea),
      .o_qea_ctx_addr    (o_qea_ctx_addr),
      .o_qea_ctx_data    (o_qea_ctx_data),
      .o_qea_state_ena   (o_qea_state_ena),
      .o_qea_state_wea   (o_qea_state_wea),
      .o_qea_state_addra (o_qea_state_addra),
      .o_qea_state_dina  (o_qea_state_dina),
      .i_qea_complete    (i_qea_complete),
`ifdef QEA_SEQ_CYCLE_COUNT_EN
      .o_exec_cycles     (o_exec_cycles),
`endif
      .i_qea_state_dout  (i_qea_state_dout)
   );

   always #5 clk = ~clk;

   function automatic logic [63:0] ctx_word(input int i);
      return {32'(i) * 32'h9E37_79B1, 32'hC0DE_0000 | 32'(i)};
   endfunction

   // Result the fake core leaves in row r after it completes
   function automatic logic [255:0] pat(input int r);
      logic [255:0] v;
      for (int k = 0; k < 4; k++) v[k*64 +: 64] = {32'hA500_0000 + 32'(r), 32'h5A00_0000 + 32'(k)};
      return v;
   endfunction

   localparam logic [255:0] INIT_ROW0 = {64'h40000000_00000000, 192'h0};

   // Behavioural state RAM, 1-cycle read latency; reads return core results once it is done
   logic [255:0] mem [0:255];
   logic         qea_done = 1'b0;
   always @(posedge clk) begin
      if (o_qea_state_ena) begin
         if (o_qea_state_wea) mem[o_qea_state_addra[7:0]] <= o_qea_state_dina;
         i_qea_state_dout <= qea_done ? pat(int'(o_qea_state_addra)) : mem[o_qea_state_addra[7:0]];
      end
   end

   // Write monitor: per-run indices restart whenever the sequencer is idle
   int ctx_idx = 0, init_idx = 0;
   int ctx_total = 0, ctx_bad = 0, init_total = 0, init_bad = 0;
   int start_total = 0, err_total = 0, strobe_total = 0;
   always @(negedge clk) begin
      if (!o_busy) begin
         ctx_idx  = 0;
         init_idx = 0;
      end
      if (o_qea_ctx_en && o_qea_ctx_wea) begin
         if (o_qea_ctx_addr !== 16'(ctx_idx) || o_qea_ctx_data !== ctx_word(ctx_idx)) ctx_bad++;
         ctx_idx++;
         ctx_total++;
      end
      if (o_qea_state_ena && o_qea_state_wea) begin
         if (o_qea_state_addra !== 16'(init_idx) ||
             o_qea_state_dina !== ((init_idx == 0) ? INIT_ROW0 : 256'h0)) init_bad++;
         init_idx++;
         init_total++;
      end
      if (o_qea_start) start_total++;
      if (o_err) err_total++;
      if (o_qea_start || o_qea_ctx_en || o_qea_ctx_wea || o_qea_state_ena || o_qea_state_wea)
         strobe_total++;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue_cmd(input int q, input int n);
      i_cmd_valid    = 1'b1;
      i_cmd_qbit_num = 6'(q);
      i_cmd_ins_num  = 16'(n);
      step();
      i_cmd_valid    = 1'b0;
   endtask

   task automatic send_ctx(input int n, output int sent);
      logic acc;
      sent = 0;
      for (int cyc = 0; cyc < 4 * n + 20 && sent < n; cyc++) begin
         i_ctx_valid = (cyc % 5 != 4);
         i_ctx_data  = ctx_word(sent);
         acc = i_ctx_valid && o_ctx_ready;
         step();
         if (acc) sent++;
      end
      i_ctx_valid = 1'b0;
   endtask

   // Fake core: raises complete for one cycle, 'delay' cycles after the start pulse is seen
   task automatic qea_run(input int delay, output int seen);
      seen = 0;
      for (int i = 0; i < 2000 && !seen; i++) begin
         if (o_qea_start) seen = 1;
         else step();
      end
      if (seen) begin
         qea_done = 1'b0;
         repeat (delay) step();
         i_qea_complete = 1'b1;
         qea_done       = 1'b1;
         step();
         i_qea_complete = 1'b0;
      end
   endtask

   task automatic read_rows(input int n, input int stall, output int got, output int data_bad,
                            output int last_bad, output int hold_bad);
      logic [255:0] obs;
      int           wait_cyc;
      got = 0; data_bad = 0; last_bad = 0; hold_bad = 0;
      while (got < n) begin
         wait_cyc = 0;
         while (!o_rd_valid && wait_cyc < 50) begin
            step();
            wait_cyc++;
         end
         if (!o_rd_valid) break;
         obs = o_rd_data;
         if (obs !== pat(got)) data_bad++;
         if (o_rd_last !== (got == n - 1)) last_bad++;
         repeat (stall) begin
            step();
            if (!o_rd_valid || o_rd_data !== obs) hold_bad++;
         end
         i_rd_ready = 1'b1;
         step();
         i_rd_ready = 1'b0;
         got++;
      end
   endtask

   task automatic test_reset();
      #3 rst_n = 1'b0;
      #1;
      n_cmp++; if (o_cmd_ready !== 1'b0) begin n_bad++; $display("FAIL reset_cmd_ready got %b want 0", o_cmd_ready); end
      n_cmp++; if (o_busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", o_busy); end
      n_cmp++; if (o_rd_valid !== 1'b0 || o_err !== 1'b0 || o_qea_start !== 1'b0)
         begin n_bad++; $display("FAIL reset_pulses got %b%b%b want 000", o_rd_valid, o_err, o_qea_start); end
      n_cmp++; if (o_qea_qbit_num !== 6'd0) begin n_bad++; $display("FAIL reset_qbit got %0d want 0", o_qea_qbit_num); end
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      step();
      n_cmp++; if (o_cmd_ready !== 1'b1) begin n_bad++; $display("FAIL release_cmd_ready got %b want 1", o_cmd_ready); end
   endtask

   task automatic test_reject();
      int s0, e0, st0;
      s0 = strobe_total; e0 = err_total; st0 = start_total;
      issue_cmd(2, 5);
      n_cmp++; if (o_err !== 1'b1) begin n_bad++; $display("FAIL reject_lo_err got %b want 1", o_err); end
      n_cmp++; if (o_cmd_ready !== 1'b1 || o_busy !== 1'b0)
         begin n_bad++; $display("FAIL reject_lo_idle got ready=%b busy=%b want 1/0", o_cmd_ready, o_busy); end
      step();
      n_cmp++; if (o_err !== 1'b0) begin n_bad++; $display("FAIL reject_err_pulse got %b want 0", o_err); end
      issue_cmd(19, 0);
      n_cmp++; if (o_err !== 1'b1) begin n_bad++; $display("FAIL reject_hi_err got %b want 1", o_err); end
      repeat (3) step();
      n_cmp++; if (strobe_total - s0 !== 0 || start_total - st0 !== 0)
         begin n_bad++; $display("FAIL reject_no_strobe got %0d want 0", strobe_total - s0); end
      n_cmp++; if (err_total - e0 !== 2) begin n_bad++; $display("FAIL reject_err_count got %0d want 2", err_total - e0); end
      n_cmp++; if (o_cmd_ready !== 1'b1) begin n_bad++; $display("FAIL reject_ready got %b want 1", o_cmd_ready); end
   endtask

   task automatic test_full_run();
      int c0, cb0, i0, ib0, st0, sent, seen, got, db, lb, hb;
      c0 = ctx_total; cb0 = ctx_bad; i0 = init_total; ib0 = init_bad; st0 = start_total;
      issue_cmd(10, 319);
      n_cmp++; if (o_busy !== 1'b1 || o_cmd_ready !== 1'b0 || o_ctx_ready !== 1'b1)
         begin n_bad++; $display("FAIL full_accept got busy=%b ready=%b ctx_ready=%b want 1/0/1", o_busy, o_cmd_ready, o_ctx_ready); end
      n_cmp++; if (o_qea_qbit_num !== 6'd10) begin n_bad++; $display("FAIL full_qbit got %0d want 10", o_qea_qbit_num); end
      send_ctx(319, sent);
      n_cmp++; if (sent !== 319) begin n_bad++; $display("FAIL full_ctx_sent got %0d want 319", sent); end
      qea_run(5, seen);
      n_cmp++; if (seen !== 1) begin n_bad++; $display("FAIL full_start_seen got %0d want 1", seen); end
      n_cmp++; if (ctx_total - c0 !== 319 || ctx_bad - cb0 !== 0)
         begin n_bad++; $display("FAIL full_ctx_writes got %0d bad=%0d want 319 bad=0", ctx_total - c0, ctx_bad - cb0); end
      n_cmp++; if (init_total - i0 !== 256 || init_bad - ib0 !== 0)
         begin n_bad++; $display("FAIL full_init_rows got %0d bad=%0d want 256 bad=0", init_total - i0, init_bad - ib0); end
      n_cmp++; if (start_total - st0 !== 1) begin n_bad++; $display("FAIL full_start_count got %0d want 1", start_total - st0); end
      read_rows(256, 0, got, db, lb, hb);
      n_cmp++; if (got !== 256 || db !== 0 || lb !== 0)
         begin n_bad++; $display("FAIL full_readout got rows=%0d data_bad=%0d last_bad=%0d want 256/0/0", got, db, lb); end
      n_cmp++; if (o_cmd_ready !== 1'b1 || o_busy !== 1'b0)
         begin n_bad++; $display("FAIL full_done got ready=%b busy=%b want 1/0", o_cmd_ready, o_busy); end
   endtask

   task automatic test_small_run();
      int i0, c0, st0, seen, got, db, lb, hb;
      i0 = init_total; c0 = ctx_total; st0 = start_total;
      issue_cmd(3, 0);
      qea_run(20, seen);
      n_cmp++; if (seen !== 1) begin n_bad++; $display("FAIL small_start_seen got %0d want 1", seen); end
      n_cmp++; if (init_total - i0 !== 2 || ctx_total - c0 !== 0 || start_total - st0 !== 1)
         begin n_bad++; $display("FAIL small_writes got init=%0d ctx=%0d start=%0d want 2/0/1", init_total - i0, ctx_total - c0, start_total - st0); end
`ifdef QEA_SEQ_CYCLE_COUNT_EN
      n_cmp++; if (o_exec_cycles !== 32'd20) begin n_bad++; $display("FAIL small_exec_cycles got %0d want 20", o_exec_cycles); end
`endif
      read_rows(2, 2, got, db, lb, hb);
      n_cmp++; if (got !== 2 || db !== 0 || lb !== 0)
         begin n_bad++; $display("FAIL small_readout got rows=%0d data_bad=%0d last_bad=%0d want 2/0/0", got, db, lb); end
      n_cmp++; if (hb !== 0) begin n_bad++; $display("FAIL small_hold_stable got %0d want 0", hb); end
      n_cmp++; if (o_cmd_ready !== 1'b1) begin n_bad++; $display("FAIL small_done got %b want 1", o_cmd_ready); end
   endtask

   task automatic test_abort_init();
      int i0, st0, found, seen, got, db, lb, hb;
      i0 = init_total; st0 = start_total; found = 0;
      issue_cmd(10, 0);
      for (int i = 0; i < 50 && !found; i++) begin
         if (o_qea_state_wea && o_qea_state_addra == 16'd5) found = 1;
         else step();
      end
      n_cmp++; if (found !== 1) begin n_bad++; $display("FAIL abort_row5_seen got %0d want 1", found); end
      i_abort = 1'b1;
      step();
      i_abort = 1'b0;
      n_cmp++; if (o_qea_state_wea !== 1'b0 || o_qea_state_ena !== 1'b0)
         begin n_bad++; $display("FAIL abort_strobes got wea=%b ena=%b want 0/0", o_qea_state_wea, o_qea_state_ena); end
      n_cmp++; if (o_busy !== 1'b0 || o_cmd_ready !== 1'b1)
         begin n_bad++; $display("FAIL abort_idle got busy=%b ready=%b want 0/1", o_busy, o_cmd_ready); end
      repeat (10) step();
      n_cmp++; if (start_total - st0 !== 0 || init_total - i0 !== 6)
         begin n_bad++; $display("FAIL abort_progress got start=%0d init=%0d want 0/6", start_total - st0, init_total - i0); end
      // Abort held while idle must not block a command
      i_abort = 1'b1;
      issue_cmd(3, 0);
      i_abort = 1'b0;
      n_cmp++; if (o_busy !== 1'b1) begin n_bad++; $display("FAIL abort_idle_ignored got %b want 1", o_busy); end
      qea_run(2, seen);
      read_rows(2, 0, got, db, lb, hb);
      n_cmp++; if (got !== 2 || db !== 0 || lb !== 0)
         begin n_bad++; $display("FAIL abort_recover got rows=%0d data_bad=%0d last_bad=%0d want 2/0/0", got, db, lb); end
   endtask

   task automatic test_reset_readout();
      int st0, cb0, sent, seen, got, db, lb, hb, w;
      st0 = start_total; cb0 = ctx_bad; w = 0;
      issue_cmd(3, 2);
      send_ctx(2, sent);
      qea_run(3, seen);
      while (!o_rd_valid && w < 50) begin step(); w++; end
      n_cmp++; if (o_rd_valid !== 1'b1) begin n_bad++; $display("FAIL rst_hold_reached got %b want 1", o_rd_valid); end
      #2 rst_n = 1'b0;
      #1;
      n_cmp++; if (o_rd_valid !== 1'b0 || o_busy !== 1'b0 || o_cmd_ready !== 1'b0)
         begin n_bad++; $display("FAIL rst_async got valid=%b busy=%b ready=%b want 0/0/0", o_rd_valid, o_busy, o_cmd_ready); end
      @(negedge clk) rst_n = 1'b1;
      step();
      n_cmp++; if (o_cmd_ready !== 1'b1) begin n_bad++; $display("FAIL rst_ready got %b want 1", o_cmd_ready); end
      issue_cmd(4, 1);
      send_ctx(1, sent);
      qea_run(4, seen);
      read_rows(4, 1, got, db, lb, hb);
      n_cmp++; if (got !== 4 || db !== 0 || lb !== 0 || hb !== 0)
         begin n_bad++; $display("FAIL rst_rerun got rows=%0d data_bad=%0d last_bad=%0d hold_bad=%0d want 4/0/0/0", got, db, lb, hb); end
      n_cmp++; if (start_total - st0 !== 2 || ctx_bad - cb0 !== 0)
         begin n_bad++; $display("FAIL rst_rerun_writes got start=%0d ctx_bad=%0d want 2/0", start_total - st0, ctx_bad - cb0); end
   endtask

   initial begin
      test_reset();
      test_reject();
      test_full_run();
      test_small_run();
      test_abort_init();
      test_reset_readout();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
